// File: rtl/sequence_checker.sv
// Multi-code combination checker: the player enters DEPTH codes, one per Go edge, which are
// compared in order against a key sequence that can be programmed while IDLE.
module sequence_checker #(
  parameter int              WIDTH        = 6,
  parameter int              DEPTH        = 4,
  parameter int              MAX_TRIES    = 3,
  parameter logic [WIDTH-1:0] DEFAULT_CODE = 6'b100101,
  localparam int             AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int             CW = (DEPTH > 1) ? $clog2(DEPTH + 1) : 1,
  localparam int             TW = $clog2(MAX_TRIES + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             startSequencer,
  input  logic             Go,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             keyWrite,
  input  logic [AW-1:0]    keyAddr,
  input  logic [WIDTH-1:0] keyData,
  output logic             correct,
  output logic             wrong,
  output logic             locked,
  output logic [CW-1:0]    entryCount,
  output logic [TW-1:0]    triesLeft
);

  typedef enum logic [1:0] {IDLE, ARMED, SOLVED, LOCKED} state_t;

  state_t                       state;
  logic                         goPrev;
  logic                         mismatch;
  logic [DEPTH-1:0][WIDTH-1:0]  key;

  logic goEdge, codeBad, lastCode, attemptBad;

  assign goEdge     = Go & ~goPrev;
  assign codeBad    = (DataIn != key[entryCount[AW-1:0]]);
  assign lastCode   = (entryCount == CW'(DEPTH - 1));
  assign attemptBad = mismatch | codeBad;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      goPrev     <= 1'b0;
      mismatch   <= 1'b0;
      correct    <= 1'b0;
      wrong      <= 1'b0;
      locked     <= 1'b0;
      entryCount <= '0;
      triesLeft  <= TW'(MAX_TRIES);
      key        <= {DEPTH{DEFAULT_CODE}};
    end else begin
      // goPrev tracks Go in every state so a press held across arming never counts
      goPrev <= Go;
      wrong  <= 1'b0;

      if (state == IDLE && keyWrite && (32'(keyAddr) < DEPTH))
        key[keyAddr] <= keyData;

      if (!startSequencer) begin
        state      <= IDLE;
        mismatch   <= 1'b0;
        correct    <= 1'b0;
        locked     <= 1'b0;
        entryCount <= '0;
        triesLeft  <= TW'(MAX_TRIES);
      end else begin
        case (state)
          IDLE: state <= ARMED;
          ARMED: begin
            if (goEdge) begin
              if (!lastCode) begin
                entryCount <= entryCount + CW'(1);
                mismatch   <= attemptBad;
              end else if (!attemptBad) begin
                state      <= SOLVED;
                correct    <= 1'b1;
                entryCount <= CW'(DEPTH);
              end else begin
                wrong      <= 1'b1;
                triesLeft  <= triesLeft - TW'(1);
                entryCount <= '0;
                mismatch   <= 1'b0;
                if (triesLeft == TW'(1)) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end
            end
          end
          default: ;  // SOLVED and LOCKED hold until startSequencer drops
        endcase
      end
    end
  end

endmodule
